riscv_hazard_ctrl: RTL and testbench

- Second-generation hazard/scheduling unit for the 5-stage core (F, D, E, M, B).
- Adds operand forwarding selects, load-use stall, a multi-cycle (mul/div) stall counter and a pending-flush register, so a branch resolved during a bus stall is not lost.
- Generalised over source-operand count and register-address width.
- Drives per-stage stall/flush controls for the F register and the FD/DE/EM/MB pipeline registers.

---
 rtl/riscv_hazard_ctrl_if.sv | 46 ++++
 rtl/riscv_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_hazard_ctrl_if.sv
// Hazard-unit bus between the pipeline (master) and riscv_hazard_ctrl (slave).
// Carries D/E/M/B operand info in and per-stage stall/flush/forward controls out.
interface riscv_hazard_ctrl_if #(
  parameter int NSRC   = 2,
  parameter int REG_AW = 5,
  parameter int MC_W   = 6,
  parameter int CNT_W  = 32
);
  logic [NSRC-1:0]        i_src_enD;
  logic [NSRC*REG_AW-1:0] i_src_addrD;
  logic [NSRC-1:0]        i_src_enE;
  logic [NSRC*REG_AW-1:0] i_src_addrE;
  logic                   i_dst_wenE, i_dst_wenM, i_dst_wenB;
  logic [REG_AW-1:0]      i_dst_addrE, i_dst_addrM, i_dst_addrB;
  logic                   i_loadE;
  logic                   i_jalD;
  logic                   i_ex_branchE;
  logic                   i_bus_stallM;
  logic                   i_mc_startE;
  logic [MC_W-1:0]        i_mc_lat;
  logic                   o_stallF, o_stallFD, o_stallDE, o_stallEM, o_stallMB;
  logic                   o_flushFD, o_flushDE, o_flushEM, o_flushMB;
  logic [2*NSRC-1:0]      o_fwd_sel;
  logic                   o_mc_busy;
  logic [CNT_W-1:0]       o_perf_stall_cnt, o_perf_flush_cnt;

  modport master (
    output i_src_enD, i_src_addrD, i_src_enE, i_src_addrE,
           i_dst_wenE, i_dst_wenM, i_dst_wenB,
           i_dst_addrE, i_dst_addrM, i_dst_addrB,
           i_loadE, i_jalD, i_ex_branchE, i_bus_stallM, i_mc_startE, i_mc_lat,
    input  o_stallF, o_stallFD, o_stallDE, o_stallEM, o_stallMB,
           o_flushFD, o_flushDE, o_flushEM, o_flushMB,
           o_fwd_sel, o_mc_busy, o_perf_stall_cnt, o_perf_flush_cnt
  );

  modport slave (
    input  i_src_enD, i_src_addrD, i_src_enE, i_src_addrE,
           i_dst_wenE, i_dst_wenM, i_dst_wenB,
           i_dst_addrE, i_dst_addrM, i_dst_addrB,
           i_loadE, i_jalD, i_ex_branchE, i_bus_stallM, i_mc_startE, i_mc_lat,
    output o_stallF, o_stallFD, o_stallDE, o_stallEM, o_stallMB,
           o_flushFD, o_flushDE, o_flushEM, o_flushMB,
           o_fwd_sel, o_mc_busy, o_perf_stall_cnt, o_perf_flush_cnt
  );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Hazard/scheduling unit for the 5-stage core: forwarding, load-use, mul/div and bus stalls,
// pending branch flush. Optional perf counters enabled by defining HAZARD_PERF_EN.
module riscv_hazard_ctrl #(
  parameter int NSRC   = 2,
  parameter int REG_AW = 5,
  parameter int MC_W   = 6,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  riscv_hazard_ctrl_if.slave  hz
);

  logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic              pend_flush_q, pend_flush_d;
  logic              ld_use, mc_busy;
  logic [4:0]        stall_v;
  logic [3:0]        flush_v;
  logic [2*NSRC-1:0] fwd_v;

  function automatic logic hit(input logic en, input logic [REG_AW-1:0] addr,
                               input logic wen, input logic [REG_AW-1:0] dst);
    return en & (addr != '0) & wen & (dst == addr);
  endfunction

  always_comb begin
    ld_use = 1'b0;
    fwd_v  = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (hz.i_loadE && hit(hz.i_src_enD[k], hz.i_src_addrD[k*REG_AW +: REG_AW],
                            hz.i_dst_wenE, hz.i_dst_addrE))
        ld_use = 1'b1;
      if (hit(hz.i_src_enE[k], hz.i_src_addrE[k*REG_AW +: REG_AW], hz.i_dst_wenM, hz.i_dst_addrM))
        fwd_v[2*k +: 2] = 2'b01;
      else if (hit(hz.i_src_enE[k], hz.i_src_addrE[k*REG_AW +: REG_AW], hz.i_dst_wenB, hz.i_dst_addrB))
        fwd_v[2*k +: 2] = 2'b10;
    end
    if (!rst_n) fwd_v = '0;
  end

  // Busy already in the start cycle so the op is held for exactly i_mc_lat cycles.
  assign mc_busy = rst_n & ((hz.i_mc_startE & (hz.i_mc_lat != '0) & (mc_cnt_q == '0))
                            | (mc_cnt_q != '0));

  // stall_v = {F, FD, DE, EM, MB}; flush_v = {FD, DE, EM, MB}
  always_comb begin
    stall_v      = 5'b0;
    flush_v      = 4'b0;
    pend_flush_d = pend_flush_q;
    mc_cnt_d     = mc_cnt_q;
    if (hz.i_bus_stallM) begin
      stall_v = 5'b11110;
      flush_v = 4'b0001;
      if (hz.i_ex_branchE) pend_flush_d = 1'b1;
    end else if (mc_busy) begin
      stall_v = 5'b11100;
      flush_v = 4'b0010;
    end else if (hz.i_ex_branchE || pend_flush_q) begin
      flush_v      = 4'b1100;
      pend_flush_d = 1'b0;
    end else if (ld_use) begin
      stall_v = 5'b11000;
      flush_v = 4'b0100;
    end else if (hz.i_jalD) begin
      flush_v = 4'b1000;
    end
    if (!hz.i_bus_stallM) begin
      if (mc_cnt_q != '0)
        mc_cnt_d = mc_cnt_q - MC_W'(1);
      else if (hz.i_mc_startE && hz.i_mc_lat != '0)
        mc_cnt_d = hz.i_mc_lat - MC_W'(1);
    end
    if (!rst_n) begin
      stall_v = 5'b0;
      flush_v = 4'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_cnt_q     <= '0;
      pend_flush_q <= 1'b0;
    end else begin
      mc_cnt_q     <= mc_cnt_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  assign {hz.o_stallF, hz.o_stallFD, hz.o_stallDE, hz.o_stallEM, hz.o_stallMB} = stall_v;
  assign {hz.o_flushFD, hz.o_flushDE, hz.o_flushEM, hz.o_flushMB}             = flush_v;
  assign hz.o_fwd_sel = fwd_v;
  assign hz.o_mc_busy = mc_busy;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  // Saturating counters, cleared only by reset.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_v[4] && perf_stall_q != '1) perf_stall_d = perf_stall_q + CNT_W'(1);
    if ((|flush_v) && perf_flush_q != '1) perf_flush_d = perf_flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign hz.o_perf_stall_cnt = perf_stall_q;
  assign hz.o_perf_flush_cnt = perf_flush_q;
`else
  assign hz.o_perf_stall_cnt = {CNT_W{1'b0}};
  assign hz.o_perf_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed self-checking bench for riscv_hazard_ctrl (default parameters).
module tb_riscv_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  riscv_hazard_ctrl_if #(.NSRC(2), .REG_AW(5), .MC_W(6), .CNT_W(32)) hz ();

  riscv_hazard_ctrl #(.NSRC(2), .REG_AW(5), .MC_W(6), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
  localparam int PERF10 = 10;
`else
  localparam int PERF10 = 0;
`endif

  always @(posedge clk) begin
    if (rst_n) assert (!(hz.i_mc_startE && hz.i_ex_branchE)) else begin
      errors++;
      $error("FAIL start_with_branch: observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stalls();
    return {27'd0, hz.o_stallF, hz.o_stallFD, hz.o_stallDE, hz.o_stallEM, hz.o_stallMB};
  endfunction

  function automatic logic [31:0] flushes();
    return {28'd0, hz.o_flushFD, hz.o_flushDE, hz.o_flushEM, hz.o_flushMB};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.i_src_enD = '0; hz.i_src_addrD = '0; hz.i_src_enE = '0; hz.i_src_addrE = '0;
    hz.i_dst_wenE = 0; hz.i_dst_wenM = 0; hz.i_dst_wenB = 0;
    hz.i_dst_addrE = '0; hz.i_dst_addrM = '0; hz.i_dst_addrB = '0;
    hz.i_loadE = 0; hz.i_jalD = 0; hz.i_ex_branchE = 0; hz.i_bus_stallM = 0;
    hz.i_mc_startE = 0; hz.i_mc_lat = '0;
  endtask

  task automatic set_load_use();
    hz.i_loadE = 1; hz.i_dst_wenE = 1; hz.i_dst_addrE = 5'd5;
    hz.i_src_enD = 2'b01; hz.i_src_addrD = {5'd0, 5'd5};
  endtask

  initial begin
    // Reset with every hazard condition asserted: outputs must still be quiet.
    rst_n = 0;
    clr();
    hz.i_bus_stallM = 1; hz.i_mc_startE = 1; hz.i_mc_lat = 6'd4; hz.i_jalD = 1;
    hz.i_src_enE = 2'b11; hz.i_src_addrE = {5'd3, 5'd3};
    hz.i_dst_wenM = 1; hz.i_dst_addrM = 5'd3;
    #3;
    chk("rst_stall", stalls(), 0);
    chk("rst_flush", flushes(), 0);
    chk("rst_fwd", 32'(hz.o_fwd_sel), 0);
    chk("rst_busy", 32'(hz.o_mc_busy), 0);
    clr();
    tick();
    rst_n = 1;
    tick();
    chk("idle_stall", stalls(), 0);
    chk("idle_flush", flushes(), 0);

    // Load-use: one stall cycle, then the dependent op in E picks the load up from B.
    set_load_use();
    #1;
    chk("lu_stall", stalls(), 32'b11000);
    chk("lu_flush", flushes(), 32'b0100);
    tick();
    clr();
    hz.i_src_enE = 2'b01; hz.i_src_addrE = {5'd0, 5'd5};
    hz.i_dst_wenB = 1; hz.i_dst_addrB = 5'd5;
    #1;
    chk("lu_after_stall", stalls(), 0);
    chk("lu_fwd_b", 32'(hz.o_fwd_sel), 32'b0010);
    tick();
    clr();
    set_load_use();
    hz.i_dst_addrE = 5'd0; hz.i_src_addrD = '0;
    #1;
    chk("lu_x0_nostall", stalls(), 0);

    // Forwarding priority and x0 exclusion.
    tick();
    clr();
    hz.i_dst_wenM = 1; hz.i_dst_addrM = 5'd3; hz.i_dst_wenB = 1; hz.i_dst_addrB = 5'd3;
    hz.i_src_enE = 2'b10; hz.i_src_addrE = {5'd3, 5'd0};
    #1;
    chk("fwd_m_prio", 32'(hz.o_fwd_sel), 32'b0100);
    hz.i_dst_addrM = 5'd9;
    #1;
    chk("fwd_b_only", 32'(hz.o_fwd_sel), 32'b1000);
    hz.i_src_enE = 2'b11; hz.i_src_addrE = {5'd9, 5'd3};
    #1;
    chk("fwd_both_src", 32'(hz.o_fwd_sel), 32'b0110);
    hz.i_src_addrE = {5'd0, 5'd0}; hz.i_dst_addrM = 5'd0; hz.i_dst_addrB = 5'd0;
    #1;
    chk("fwd_x0", 32'(hz.o_fwd_sel), 0);
    hz.i_src_enE = 2'b00; hz.i_src_addrE = {5'd9, 5'd3}; hz.i_dst_addrM = 5'd9;
    #1;
    chk("fwd_disabled", 32'(hz.o_fwd_sel), 0);

    // Multi-cycle lat=4: busy and flushEM for exactly four cycles.
    tick();
    clr();
    hz.i_mc_startE = 1; hz.i_mc_lat = 6'd4;
    #1;
    chk("mc4_busy0", 32'(hz.o_mc_busy), 1);
    chk("mc4_stall0", stalls(), 32'b11100);
    chk("mc4_flush0", flushes(), 32'b0010);
    tick();
    clr();
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("mc4_busy%0d", i), 32'(hz.o_mc_busy), 1);
      chk($sformatf("mc4_flush%0d", i), flushes(), 32'b0010);
      tick();
    end
    chk("mc4_done", 32'(hz.o_mc_busy), 0);
    chk("mc4_done_stall", stalls(), 0);
    hz.i_mc_startE = 1; hz.i_mc_lat = 6'd0;
    #1;
    chk("mc0_nobusy", 32'(hz.o_mc_busy), 0);
    chk("mc0_nostall", stalls(), 0);

    // Branches during a 3-cycle bus stall collapse into one flush after release.
    tick();
    clr();
    hz.i_bus_stallM = 1; hz.i_ex_branchE = 1;
    #1;
    chk("bs_stall1", stalls(), 32'b11110);
    chk("bs_flush1", flushes(), 32'b0001);
    tick();
    hz.i_ex_branchE = 0;
    #1;
    chk("bs_flush2", flushes(), 32'b0001);
    tick();
    hz.i_ex_branchE = 1;
    #1;
    chk("bs_flush3", flushes(), 32'b0001);
    tick();
    clr();
    #1;
    chk("bs_release_flush", flushes(), 32'b1100);
    chk("bs_release_stall", stalls(), 0);
    tick();
    chk("bs_pend_cleared", flushes(), 0);
    hz.i_ex_branchE = 1; hz.i_jalD = 1;
    #1;
    chk("br_over_jal", flushes(), 32'b1100);
    hz.i_ex_branchE = 0;
    #1;
    chk("jal_only", flushes(), 32'b1000);

    // Bus stall in the middle of a lat=3 op stretches busy to five cycles.
    tick();
    clr();
    hz.i_mc_startE = 1; hz.i_mc_lat = 6'd3;
    #1;
    chk("mcb_c0", 32'(hz.o_mc_busy), 1);
    tick();
    clr();
    chk("mcb_c1", 32'(hz.o_mc_busy), 1);
    tick();
    hz.i_bus_stallM = 1;
    #1;
    chk("mcb_c2", 32'(hz.o_mc_busy), 1);
    chk("mcb_c2_bus_prio", flushes(), 32'b0001);
    tick();
    chk("mcb_c3", 32'(hz.o_mc_busy), 1);
    tick();
    hz.i_bus_stallM = 0;
    #1;
    chk("mcb_c4", 32'(hz.o_mc_busy), 1);
    tick();
    chk("mcb_c5_done", 32'(hz.o_mc_busy), 0);

    // Perf counters from a clean reset, then reset in the middle of an mc op.
    rst_n = 0;
    #1;
    rst_n = 1;
    tick();
    set_load_use();
    for (int i = 0; i < 10; i++) tick();
    clr();
    #1;
    chk("perf_stall10", hz.o_perf_stall_cnt, PERF10);
    chk("perf_flush10", hz.o_perf_flush_cnt, PERF10);
    hz.i_mc_startE = 1; hz.i_mc_lat = 6'd10;
    tick();
    clr();
    tick();
    chk("mid_busy", 32'(hz.o_mc_busy), 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(hz.o_mc_busy), 0);
    chk("arst_stall", stalls(), 0);
    chk("arst_flush", flushes(), 0);
    chk("arst_perf_stall", hz.o_perf_stall_cnt, 0);
    chk("arst_perf_flush", hz.o_perf_flush_cnt, 0);
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_busy", 32'(hz.o_mc_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
